pipe_hazard_ctrl: RTL and testbench

- Consumer end of the pipeline stall/flush interface.
- Takes hazard requests and turns them into per-stage hold/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Requests come from the load-use detector, the EX-stage branch/jump redirect, and the instruction/data memory busy signals.
- Holds a pending redirect across data-memory stalls and keeps saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: turns load-use, redirect and memory-busy requests
// into per-stage hold/flush controls, parks redirects across data-memory stalls.
module pipe_hazard_ctrl #(
   parameter int unsigned PC_W  = 64,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_stall,
   input  logic             redirect_valid,
   input  logic [PC_W-1:0]  redirect_pc,
   input  logic             imem_busy,
   input  logic             dmem_busy,
   output logic             pc_hold,
   output logic             pc_load,
   output logic [PC_W-1:0]  pc_target,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             idex_hold,
   output logic             idex_flush,
   output logic             exmem_hold,
   output logic             memwb_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

   state_t            state_q, state_nxt;
   logic              pend_valid_q, pend_valid_nxt;
   logic [PC_W-1:0]   pend_pc_q, pend_pc_nxt;
   logic [CNT_W-1:0]  stall_q, flush_q;
   logic              run_eval;

   // State, pending redirect and saturating counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
         stall_q      <= '0;
         flush_q      <= '0;
      end else begin
         state_q      <= state_nxt;
         pend_valid_q <= pend_valid_nxt;
         pend_pc_q    <= pend_pc_nxt;
         if (pc_hold && !pc_load && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + CNT_W'(1);
         if (pc_load && (flush_q != {CNT_W{1'b1}}))
            flush_q <= flush_q + CNT_W'(1);
      end
   end

   // Next state and per-stage controls
   always_comb begin
      state_nxt      = state_q;
      pend_valid_nxt = pend_valid_q;
      pend_pc_nxt    = pend_pc_q;
      run_eval       = 1'b0;
      pc_hold        = 1'b0;
      pc_load        = 1'b0;
      pc_target      = '0;
      ifid_hold      = 1'b0;
      ifid_flush     = 1'b0;
      idex_hold      = 1'b0;
      idex_flush     = 1'b0;
      exmem_hold     = 1'b0;
      memwb_bubble   = 1'b0;

      case (state_q)
         RUN: begin
            if (dmem_busy) begin
               pc_hold      = 1'b1;
               ifid_hold    = 1'b1;
               idex_hold    = 1'b1;
               exmem_hold   = 1'b1;
               memwb_bubble = 1'b1;
               state_nxt    = MEM_WAIT;
               if (redirect_valid) begin
                  pend_valid_nxt = 1'b1;
                  pend_pc_nxt    = redirect_pc;
               end
            end else begin
               run_eval = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_busy) begin
               pc_hold      = 1'b1;
               ifid_hold    = 1'b1;
               idex_hold    = 1'b1;
               exmem_hold   = 1'b1;
               memwb_bubble = 1'b1;
               // first redirect seen during the stall wins; later ones are squashed
               if (!pend_valid_q && redirect_valid) begin
                  pend_valid_nxt = 1'b1;
                  pend_pc_nxt    = redirect_pc;
               end
            end else begin
               state_nxt = RUN;
               if (pend_valid_q) begin
                  pc_load        = 1'b1;
                  pc_target      = pend_pc_q;
                  ifid_flush     = 1'b1;
                  idex_flush     = 1'b1;
                  pend_valid_nxt = 1'b0;
               end else begin
                  run_eval = 1'b1;
               end
            end
         end
      endcase

      // Normal-flow priority: redirect squashes everything younger than EX
      if (run_eval) begin
         if (redirect_valid) begin
            pc_load    = 1'b1;
            pc_target  = redirect_pc;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use_stall) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
         end else if (imem_busy) begin
            pc_hold    = 1'b1;
            ifid_flush = 1'b1;
         end
      end

      if (!rst_n) begin
         pc_hold      = 1'b0;
         pc_load      = 1'b0;
         pc_target    = '0;
         ifid_hold    = 1'b0;
         ifid_flush   = 1'b0;
         idex_hold    = 1'b0;
         idex_flush   = 1'b0;
         exmem_hold   = 1'b0;
         memwb_bubble = 1'b0;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

   localparam int unsigned PC_W  = 64;
   localparam int unsigned CNT_W = 32;

   localparam logic [7:0] C_NONE  = 8'b0000_0000;
   localparam logic [7:0] C_DMEM  = 8'b1010_1011;
   localparam logic [7:0] C_REDIR = 8'b0101_0100;
   localparam logic [7:0] C_LU    = 8'b1010_0100;
   localparam logic [7:0] C_IMEM  = 8'b1001_0000;

   typedef struct {
      logic [7:0]       ctrl;
      logic [PC_W-1:0]  pc;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
      string            tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             load_use_stall = 1'b0;
   logic             redirect_valid = 1'b0;
   logic [PC_W-1:0]  redirect_pc = '0;
   logic             imem_busy = 1'b0;
   logic             dmem_busy = 1'b0;
   logic             pc_hold, pc_load, ifid_hold, ifid_flush;
   logic             idex_hold, idex_flush, exmem_hold, memwb_bubble;
   logic [PC_W-1:0]  pc_target;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   pipe_hazard_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_use_stall(load_use_stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
      .pc_hold(pc_hold), .pc_load(pc_load), .pc_target(pc_target),
      .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
      .idex_hold(idex_hold), .idex_flush(idex_flush),
      .exmem_hold(exmem_hold), .memwb_bubble(memwb_bubble),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ctrl_vec();
      return {pc_hold, pc_load, ifid_hold, ifid_flush,
              idex_hold, idex_flush, exmem_hold, memwb_bubble};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every cycle with a pending expectation is compared mid-cycle
   always @(negedge clk) begin
      if (rst_n && exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.tag, " ctrl"}, 64'(ctrl_vec()), 64'(e.ctrl));
         chk({e.tag, " pc_target"}, 64'(pc_target), 64'(e.pc));
         chk({e.tag, " stall_cnt"}, 64'(stall_cnt), 64'(e.sc));
         chk({e.tag, " flush_cnt"}, 64'(flush_cnt), 64'(e.fc));
      end
   end

   task automatic step(input logic lu, input logic rv, input logic [PC_W-1:0] rpc,
                       input logic im, input logic dm, input logic [7:0] ectrl,
                       input logic [PC_W-1:0] epc, input logic [CNT_W-1:0] es,
                       input logic [CNT_W-1:0] ef, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      load_use_stall = lu;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_busy      = im;
      dmem_busy      = dm;
      e.ctrl = ectrl; e.pc = epc; e.sc = es; e.fc = ef; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef, input string tag);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, C_NONE, '0, es, ef, tag);
   endtask

   // Async reset between edges; inputs are left as they are when it drops
   task automatic do_reset(input string tag);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk({tag, " reset ctrl"}, 64'(ctrl_vec()), 64'(C_NONE));
      chk({tag, " reset pc_target"}, 64'(pc_target), 64'd0);
      chk({tag, " reset stall_cnt"}, 64'(stall_cnt), 64'd0);
      chk({tag, " reset flush_cnt"}, 64'(flush_cnt), 64'd0);
      load_use_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_busy = 1'b0; dmem_busy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset("init");

      for (int i = 0; i < 10; i++) idle(0, 0, "idle");

      step(1, 0, '0, 0, 0, C_LU, '0, 0, 0, "load_use");
      idle(1, 0, "after_lu");

      step(1, 1, 64'h8000_0040, 0, 0, C_REDIR, 64'h8000_0040, 1, 0, "redir_vs_lu");
      idle(1, 1, "after_redir");

      do_reset("pre_pend");
      step(0, 1, 64'h1000, 0, 1, C_DMEM, '0, 0, 0, "busy1");
      step(0, 1, 64'h2000, 0, 1, C_DMEM, '0, 1, 0, "busy2");
      step(0, 0, '0,       0, 1, C_DMEM, '0, 2, 0, "busy3");
      step(0, 0, '0,       0, 0, C_REDIR, 64'h1000, 3, 0, "pend_release");
      idle(3, 1, "after_pend");

      step(0, 0, '0, 0, 1, C_DMEM, '0, 3, 1, "busy_nopend");
      step(0, 0, '0, 1, 0, C_IMEM, '0, 4, 1, "release_imem");
      idle(5, 1, "after_rel_imem");

      step(0, 1, 64'h3000, 0, 1, C_DMEM, '0, 5, 1, "busy_pend2");
      step(1, 1, 64'h4000, 0, 0, C_REDIR, 64'h3000, 6, 1, "release_ignores_live");
      idle(6, 2, "after_rel_live");

      step(0, 1, 64'h5000, 1, 0, C_REDIR, 64'h5000, 6, 2, "redir_vs_imem");
      idle(6, 3, "after_redir_imem");
      step(0, 0, 64'hdead, 1, 0, C_IMEM, '0, 6, 3, "imem_only");
      idle(7, 3, "after_imem");

      step(0, 1, 64'h1000, 0, 1, C_DMEM, '0, 7, 3, "busy_before_rst");
      do_reset("mid_wait");
      idle(0, 0, "post_rst_1");
      idle(0, 0, "post_rst_2");

      @(posedge clk);
      #1;
      force dut.stall_q = {{(CNT_W-1){1'b1}}, 1'b0};
      #1;
      release dut.stall_q;
      step(0, 0, '0, 1, 0, C_IMEM, '0, 32'hFFFF_FFFE, 0, "sat1");
      step(0, 0, '0, 1, 0, C_IMEM, '0, 32'hFFFF_FFFF, 0, "sat2");
      step(0, 0, '0, 1, 0, C_IMEM, '0, 32'hFFFF_FFFF, 0, "sat3");
      step(0, 0, '0, 1, 0, C_IMEM, '0, 32'hFFFF_FFFF, 0, "sat4");
      idle(32'hFFFF_FFFF, 0, "sat_hold");

      repeat (3) @(posedge clk);
      chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
